mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_rr.sv | 38 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, channel indices and request-flag helpers
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam logic CH_D = 1'b0;
    localparam logic CH_I = 1'b1;

    localparam int RWE_R = 0;
    localparam int RWE_W = 1;

    // Read/write flag pair belonging to one channel
    function automatic logic [1:0] rwe_pair(input logic [3:0] rwe, input logic ch);
        return ch ? rwe[3:2] : rwe[1:0];
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way grant select; MEM_ARB_FIXED_PRIO_EN gives channel 0 fixed priority
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_gnt;

    // Remember which channel won most recently; starts at 1 so channel 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= CH_I;
        end else if (take) begin
            last_gnt <= gnt_idx;
        end
    end

    // Pick a winner among the pending channels
    always_comb begin
        gnt_valid = |req;
`ifdef MEM_ARB_FIXED_PRIO_EN
        gnt_idx = req[CH_D] ? CH_D : CH_I;
`else
        if (req[CH_D] && req[CH_I]) begin
            gnt_idx = ~last_gnt;
        end else begin
            gnt_idx = req[CH_I] ? CH_I : CH_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-channel CPU to single-port memory arbiter (MEM_ARB_FIXED_PRIO_EN selects fixed priority)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          cpu_rwe_i,
    input  logic [2*ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]          cpu_sel_i,
    input  logic [2*DATA_W-1:0] cpu_data_i,
    output logic [2*DATA_W-1:0] cpu_data_o,
    output logic [1:0]          cpu_busy_o,
    output logic [1:0]          cpu_done_o,
    output logic                ram_req_o,
    output logic                ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [3:0]          ram_sel_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic                ram_ack_i,
    input  logic [DATA_W-1:0]   ram_rdata_i
);

    arb_state_t state, state_nxt;

    logic [1:0][ADDR_W-1:0] addr_v;
    logic [1:0][3:0]        sel_v;
    logic [1:0][DATA_W-1:0] wdata_v;
    logic [1:0][DATA_W-1:0] rdata_q;
    logic [1:0]             pend;
    logic [1:0]             gnt_pair;
    logic [1:0]             busy_q;
    logic [1:0]             done_q;
    logic                   gnt_valid;
    logic                   gnt_idx;
    logic                   take;
    logic                   cur_ch;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [3:0]             sel_q;
    logic [DATA_W-1:0]      wdata_q;

    assign addr_v  = cpu_addr_i;
    assign sel_v   = cpu_sel_i;
    assign wdata_v = cpu_data_i;

    // A channel is pending while it asserts any flag and is not in its completion cycle
    always_comb begin
        pend = '0;
        for (int c = 0; c < 2; c++) begin
            pend[c] = (rwe_pair(cpu_rwe_i, c[0])[RWE_R] | rwe_pair(cpu_rwe_i, c[0])[RWE_W])
                      & ~done_q[c];
        end
    end

    assign gnt_pair = rwe_pair(cpu_rwe_i, gnt_idx);

    mem_arb_rr u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (pend),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant acceptance and the downstream request strobe
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        ram_req_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ram_req_o = 1'b1;
                if (ram_ack_i) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request, capture read data on ack, drive busy and done
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch  <= CH_D;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= '0;
            if (take) begin
                cur_ch          <= gnt_idx;
                we_q            <= gnt_pair[RWE_W];
                addr_q          <= addr_v[gnt_idx];
                sel_q           <= sel_v[gnt_idx];
                wdata_q         <= wdata_v[gnt_idx];
                busy_q[gnt_idx] <= 1'b1;
            end
            if (state == ISSUE && ram_ack_i) begin
                done_q[cur_ch] <= 1'b1;
                if (!we_q) begin
                    rdata_q[cur_ch] <= ram_rdata_i;
                end
            end
            if (state == RESP) begin
                busy_q[cur_ch] <= 1'b0;
            end
        end
    end

    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_sel_o   = sel_q;
    assign ram_wdata_o = wdata_q;
    assign cpu_busy_o  = busy_q;
    assign cpu_done_o  = done_q;
    assign cpu_data_o  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  cpu_rwe_i;
    logic [63:0] cpu_addr_i;
    logic [7:0]  cpu_sel_i;
    logic [63:0] cpu_data_i;
    logic [63:0] cpu_data_o;
    logic [1:0]  cpu_busy_o;
    logic [1:0]  cpu_done_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_wdata_o;
    logic        ram_ack_i;
    logic [31:0] ram_rdata_i;

    typedef struct {
        logic        ch;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   rem[2];
    int   passed = 0;
    int   total  = 0;

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_rwe_i   (cpu_rwe_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_sel_i   (cpu_sel_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_busy_o  (cpu_busy_o),
        .cpu_done_o  (cpu_done_o),
        .ram_req_o   (ram_req_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_sel_o   (ram_sel_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_ack_i   (ram_ack_i),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic ch, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.ch = ch; t.we = we; t.addr = addr; t.sel = sel; t.wdata = wdata; t.rdata = rdata;
        sb.push_back(t);
    endtask

    task automatic drive(input logic ch, input logic [1:0] pair, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata);
        cpu_rwe_i[ch*2 +: 2]   = pair;
        cpu_addr_i[ch*32 +: 32] = addr;
        cpu_sel_i[ch*4 +: 4]   = sel;
        cpu_data_i[ch*32 +: 32] = wdata;
        rem[ch] = rem[ch] + 1;
    endtask

    // Memory model plus requester model: acks after 'waits' cycles, checks every cycle at negedge
    task automatic service(input int waits, input int max_cyc);
        int   wcnt = 0;
        int   cyc  = 0;
        txn_t t;
        while (sb.size() > 0 && cyc < max_cyc) begin
            ram_ack_i = 1'b0;
            if (ram_req_o) begin
                t = sb[0];
                chk("req_we", ram_we_o, t.we);
                chk("req_addr", ram_addr_o, t.addr);
                chk("req_sel", ram_sel_o, t.sel);
                if (t.we) chk("req_wdata", ram_wdata_o, t.wdata);
                chk("req_busy", cpu_busy_o, 2'b01 << t.ch);
                if (wcnt == waits) begin
                    ram_ack_i   = 1'b1;
                    ram_rdata_i = t.rdata;
                    wcnt        = 0;
                end else begin
                    wcnt++;
                end
            end
            if (cpu_done_o != 2'b00) begin
                t = sb.pop_front();
                chk("done_ch", cpu_done_o, 2'b01 << t.ch);
                if (!t.we) chk("rdata", cpu_data_o[t.ch*32 +: 32], t.rdata);
                rem[t.ch] = rem[t.ch] - 1;
                if (rem[t.ch] <= 0) cpu_rwe_i[t.ch*2 +: 2] = 2'b00;
            end
            if (sb.size() > 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        ram_ack_i = 1'b0;
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst = 1'b1;
        cpu_rwe_i = '0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
        ram_ack_i = 1'b0; ram_rdata_i = '0;
        rem[0] = 0; rem[1] = 0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_req", ram_req_o, 0);
        chk("rst_we", ram_we_o, 0);
        chk("rst_addr", ram_addr_o, 0);
        chk("rst_sel", ram_sel_o, 0);
        chk("rst_wdata", ram_wdata_o, 0);
        chk("rst_busy", cpu_busy_o, 0);
        chk("rst_done", cpu_done_o, 0);
        chk("rst_data", cpu_data_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Channel 0 read with two wait cycles
        drive(1'b0, 2'b01, 32'h100, 4'h0, 32'h0);
        push(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_req_lat", ram_req_o, 1);
        chk("rd_busy", cpu_busy_o, 2'b01);
        service(2, 50);
        @(negedge clk);
        chk("rd_done_once", cpu_done_o, 0);
        chk("rd_busy_clr", cpu_busy_o, 0);
        chk("rd_hold", cpu_data_o[31:0], 32'hDEADBEEF);

        // Channel 1 write with partial byte mask
        drive(1'b1, 2'b10, 32'h40, 4'b0011, 32'h1234);
        push(1'b1, 1'b1, 32'h40, 4'b0011, 32'h1234, 32'hFFFF_FFFF);
        service(0, 50);
        @(negedge clk);
        chk("wr_done_once", cpu_done_o, 0);
        chk("wr_data1_keep", cpu_data_o[63:32], 0);
        chk("wr_data0_keep", cpu_data_o[31:0], 32'hDEADBEEF);

        // Read+write flags together count as a write
        drive(1'b0, 2'b11, 32'h80, 4'hF, 32'hA5A5_0001);
        push(1'b0, 1'b1, 32'h80, 4'hF, 32'hA5A5_0001, 32'h1111_2222);
        service(0, 50);
        @(negedge clk);
        chk("rw_data0_keep", cpu_data_o[31:0], 32'hDEADBEEF);

        // Spurious ack while idle
        ram_ack_i = 1'b1;
        @(negedge clk);
        ram_ack_i = 1'b0;
        chk("spur_done", cpu_done_o, 0);
        chk("spur_busy", cpu_busy_o, 0);
        chk("spur_req", ram_req_o, 0);
        @(negedge clk);
        chk("spur_done2", cpu_done_o, 0);
        drive(1'b1, 2'b01, 32'h44, 4'h0, 32'h0);
        push(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 32'h0BAD_F00D);
        @(negedge clk);
        chk("spur_then_req", ram_req_o, 1);
        service(1, 50);

        // Reset in the middle of a transaction
        @(negedge clk);
        drive(1'b0, 2'b01, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk("mid_req", ram_req_o, 1);
        rst = 1'b1;
        cpu_rwe_i = '0;
        rem[0] = 0; rem[1] = 0;
        @(negedge clk);
        chk("mid_rst_req", ram_req_o, 0);
        chk("mid_rst_busy", cpu_busy_o, 0);
        chk("mid_rst_done", cpu_done_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_no_done", cpu_done_o, 0);
        drive(1'b0, 2'b01, 32'h20, 4'h0, 32'h0);
        push(1'b0, 1'b0, 32'h20, 4'h0, 32'h0, 32'h5555_AAAA);
        service(0, 50);

        // Both channels read simultaneously for three rounds from a fresh pointer
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rem[0] = 0; rem[1] = 0;
        drive(1'b0, 2'b01, 32'h200, 4'h0, 32'h0);
        drive(1'b1, 2'b01, 32'h300, 4'h0, 32'h0);
        rem[0] = 3; rem[1] = 3;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 6; i++) begin
            if (i < 3) push(1'b0, 1'b0, 32'h200, 4'h0, 32'h0, 32'hC0DE_0000 | (i << 4));
            else       push(1'b1, 1'b0, 32'h300, 4'h0, 32'h0, 32'hC0DE_0001 | (i << 4));
        end
`else
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push(1'b0, 1'b0, 32'h200, 4'h0, 32'h0, 32'hC0DE_0000 | (i << 4));
            else            push(1'b1, 1'b0, 32'h300, 4'h0, 32'h0, 32'hC0DE_0001 | (i << 4));
        end
`endif
        service(1, 300);
        @(negedge clk);
        chk("rr_idle_busy", cpu_busy_o, 0);
        chk("rr_idle_req", ram_req_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
